// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with valid/ready byte intake; SerialOut is registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] DataIn,
   input  logic       DataInValid,
   output logic       DataInReady,
   output logic       SerialOut
);
   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : gBadBaud
         $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } stateType;

   stateType        state, stateNext;
   logic [CntW-1:0] baudCnt, baudNext;
   logic [2:0]      bitIdx, idxNext;
   logic [7:0]      shiftReg, shiftNext;
   logic            serialReg, serialNext;
   logic            bitDone;
`ifdef UART_TX_PARITY_EN
   logic            parityBit, parityNext;
`endif

   assign bitDone     = (baudCnt == LastCnt);
   assign DataInReady = (state == IDLE);
   assign SerialOut   = serialReg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         baudCnt   <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         serialReg <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parityBit <= 1'b0;
`endif
      end else begin
         state     <= stateNext;
         baudCnt   <= baudNext;
         bitIdx    <= idxNext;
         shiftReg  <= shiftNext;
         serialReg <= serialNext;
`ifdef UART_TX_PARITY_EN
         parityBit <= parityNext;
`endif
      end
   end

   // serialNext is the line value for the cycle after this edge, so each
   // transition computes the level of the bit it is entering.
   always_comb begin
      stateNext  = state;
      baudNext   = baudCnt + 1'b1;
      idxNext    = bitIdx;
      shiftNext  = shiftReg;
      serialNext = serialReg;
`ifdef UART_TX_PARITY_EN
      parityNext = parityBit;
`endif
      case (state)
         IDLE: begin
            baudNext   = '0;
            serialNext = 1'b1;
            if (DataInValid) begin
               stateNext  = START;
               shiftNext  = DataIn;
               idxNext    = '0;
               serialNext = 1'b0;
`ifdef UART_TX_PARITY_EN
               parityNext = ^DataIn;
`endif
            end
         end
         START: begin
            if (bitDone) begin
               baudNext   = '0;
               stateNext  = DATA;
               serialNext = shiftReg[0];
            end
         end
         DATA: begin
            if (bitDone) begin
               baudNext = '0;
               if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  stateNext  = PARITY;
                  serialNext = parityBit;
`else
                  stateNext  = STOP;
                  serialNext = 1'b1;
`endif
               end else begin
                  idxNext    = bitIdx + 3'd1;
                  shiftNext  = {1'b0, shiftReg[7:1]};
                  serialNext = shiftReg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bitDone) begin
               baudNext   = '0;
               stateNext  = STOP;
               serialNext = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bitDone) begin
               baudNext   = '0;
               stateNext  = IDLE;
               serialNext = 1'b1;
            end
         end
         default: begin
            baudNext   = '0;
            stateNext  = IDLE;
            serialNext = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 16 clocks per bit; expected
// frames are queued at handshake time and compared against the captured line.
module tb_uart_transmitter;
   localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk;
   logic       reset;
   logic [7:0] DataIn;
   logic       DataInValid;
   logic       DataInReady;
   logic       SerialOut;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int hsQ[$];
   logic [NB-1:0] sbQ[$];

   uart_transmitter #(.CLOCK_FREQ(16), .BAUD_RATE(1)) dut (
      .clk(clk), .reset(reset), .DataIn(DataIn), .DataInValid(DataInValid),
      .DataInReady(DataInReady), .SerialOut(SerialOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // records the cycle number of every accepted byte
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset && DataInValid === 1'b1 && DataInReady === 1'b1) hsQ.push_back(cyc);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [NB-1:0] expFrame(input logic [7:0] d);
      logic [NB-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ^d;
`endif
      f[NB-1] = 1'b1;
      return f;
   endfunction

   // Samples the line at every negedge for NB bit periods starting right
   // after the handshake edge; reports bit levels, hold stability and
   // the number of cycles DataInReady was low.
   task automatic capture_frame(output logic [NB-1:0] bits, output bit stable, output int rdyLow);
      logic v;
      bits = '0; stable = 1'b1; rdyLow = 0; v = 1'b0;
      for (int b = 0; b < NB; b++) begin
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (c == 0) v = SerialOut;
            else if (SerialOut !== v) stable = 1'b0;
            if (DataInReady === 1'b0) rdyLow++;
         end
         bits[b] = v;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; DataInValid = 1'b0; DataIn = 8'h00;
      #2;
      total++;
      if (SerialOut !== 1'b1 || DataInReady !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: got ser=%b rdy=%b want ser=1 rdy=1", SerialOut, DataInReady);
      end
      @(posedge clk); #1; reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         total++;
         if (SerialOut !== 1'b1 || DataInReady !== 1'b1) begin
            bad++;
            $display("FAIL idle_cycle%0d: got ser=%b rdy=%b want ser=1 rdy=1", i, SerialOut, DataInReady);
         end
      end
   endtask

   task automatic test_single_byte(input logic [7:0] d);
      logic [NB-1:0] got, exp;
      bit stab; int rl; int hs0;
      hs0 = hsQ.size();
      @(posedge clk); #1; DataIn = d; DataInValid = 1'b1; sbQ.push_back(expFrame(d));
      @(posedge clk); #1; DataInValid = 1'b0;
      capture_frame(got, stab, rl);
      exp = sbQ.pop_front();
      total++;
      if (got !== exp) begin
         bad++; $display("FAIL frame_%h: got %b want %b", d, got, exp);
      end
      total++;
      if (!stab) begin
         bad++; $display("FAIL hold_%h: got unstable bit want stable %0d cycles", d, CPB);
      end
      total++;
      if (rl !== NB*CPB) begin
         bad++; $display("FAIL ready_low_%h: got %0d want %0d", d, rl, NB*CPB);
      end
`ifdef UART_TX_PARITY_EN
      total++;
      if (got[9] !== ^d) begin
         bad++; $display("FAIL parity_%h: got %b want %b", d, got[9], ^d);
      end
`endif
      @(negedge clk);
      total++;
      if (DataInReady !== 1'b1 || SerialOut !== 1'b1) begin
         bad++; $display("FAIL ready_after_%h: got rdy=%b ser=%b want 1 1", d, DataInReady, SerialOut);
      end
      total++;
      if (hsQ.size() !== hs0 + 1) begin
         bad++; $display("FAIL hs_count_%h: got %0d want %0d", d, hsQ.size() - hs0, 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [NB-1:0] got, exp;
      bit stab; int rl; int hs0;
      hs0 = hsQ.size();
      @(posedge clk); #1; DataIn = 8'h00; DataInValid = 1'b1; sbQ.push_back(expFrame(8'h00));
      @(posedge clk); #1; DataIn = 8'hFF; sbQ.push_back(expFrame(8'hFF));
      capture_frame(got, stab, rl);
      exp = sbQ.pop_front();
      total++;
      if (got !== exp || !stab) begin
         bad++; $display("FAIL b2b_frame0: got %b stable=%b want %b stable=1", got, stab, exp);
      end
      @(negedge clk);
      total++;
      if (SerialOut !== 1'b1 || DataInReady !== 1'b1) begin
         bad++; $display("FAIL b2b_stop_ext: got ser=%b rdy=%b want 1 1", SerialOut, DataInReady);
      end
      @(posedge clk); #1; DataInValid = 1'b0;
      capture_frame(got, stab, rl);
      exp = sbQ.pop_front();
      total++;
      if (got !== exp || !stab) begin
         bad++; $display("FAIL b2b_frame1: got %b stable=%b want %b stable=1", got, stab, exp);
      end
      total++;
      if (hsQ.size() !== hs0 + 2) begin
         bad++; $display("FAIL b2b_hs_count: got %0d want 2", hsQ.size() - hs0);
      end else begin
         total++;
         if (hsQ[hs0+1] - hsQ[hs0] !== NB*CPB + 1) begin
            bad++; $display("FAIL b2b_spacing: got %0d want %0d", hsQ[hs0+1] - hsQ[hs0], NB*CPB + 1);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_busy();
      logic [NB-1:0] got, exp;
      bit stab; int rl; int hs0;
      hs0 = hsQ.size();
      @(posedge clk); #1; DataIn = 8'h81; DataInValid = 1'b1; sbQ.push_back(expFrame(8'h81));
      @(posedge clk); #1; DataInValid = 1'b0;
      fork
         capture_frame(got, stab, rl);
         begin
            repeat (40) @(posedge clk);
            #1; DataIn = 8'h3C; DataInValid = 1'b1;
            @(posedge clk); #1; DataInValid = 1'b0;
         end
      join
      exp = sbQ.pop_front();
      total++;
      if (got !== exp || !stab) begin
         bad++; $display("FAIL busy_frame: got %b stable=%b want %b stable=1", got, stab, exp);
      end
      total++;
      if (rl !== NB*CPB) begin
         bad++; $display("FAIL busy_ready_low: got %0d want %0d", rl, NB*CPB);
      end
      total++;
      if (hsQ.size() !== hs0 + 1) begin
         bad++; $display("FAIL busy_hs_count: got %0d want 1", hsQ.size() - hs0);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [NB-1:0] got, exp, dropped;
      bit stab; int rl;
      @(posedge clk); #1; DataIn = 8'h55; DataInValid = 1'b1; sbQ.push_back(expFrame(8'h55));
      @(posedge clk); #1; DataInValid = 1'b0;
      repeat (70) @(negedge clk);
      total++;
      if (SerialOut !== 1'b0 || DataInReady !== 1'b0) begin
         bad++; $display("FAIL pre_reset_line: got ser=%b rdy=%b want 0 0", SerialOut, DataInReady);
      end
      #1; reset = 1'b1;
      #1;
      total++;
      if (SerialOut !== 1'b1 || DataInReady !== 1'b1) begin
         bad++; $display("FAIL async_reset: got ser=%b rdy=%b want 1 1", SerialOut, DataInReady);
      end
      dropped = sbQ.pop_front();
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      total++;
      if (SerialOut !== 1'b1 || DataInReady !== 1'b1) begin
         bad++; $display("FAIL post_reset_idle: got ser=%b rdy=%b want 1 1 (dropped %b)", SerialOut, DataInReady, dropped);
      end
      @(posedge clk); #1; DataIn = 8'h55; DataInValid = 1'b1; sbQ.push_back(expFrame(8'h55));
      @(posedge clk); #1; DataInValid = 1'b0;
      capture_frame(got, stab, rl);
      exp = sbQ.pop_front();
      total++;
      if (got !== exp || !stab || rl !== NB*CPB) begin
         bad++; $display("FAIL post_reset_frame: got %b stable=%b rdyLow=%0d want %b 1 %0d", got, stab, rl, exp, NB*CPB);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_byte(8'hA5);
      total++;
      if (expFrame(8'hA5) !== NB'({1'b1, 8'hA5, 1'b0}) && NB == 10) begin
         bad++; $display("FAIL model_a5: got %b", expFrame(8'hA5));
      end
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_single_byte(8'h07);
      test_single_byte(8'h03);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
